// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared controller state encoding and default operand width.
package mod_exp_pkg;
  localparam int WIDTH_DEF = 192;
  typedef enum logic [2:0] {
    IDLE,
    SQR_ISSUE,
    SQR_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    NEXT,
    DONE
  } state_t;
endpackage

// File: rtl/lz_msb_find.sv
// lz_msb_find: index of the most significant set bit of vec_i (0 when vec_i is 0).
module lz_msb_find #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] msb_o
);
  always_comb begin
    msb_o = '0;
    for (int i = 0; i < WIDTH; i++)
      if (vec_i[i]) msb_o = i[$clog2(WIDTH)-1:0];
  end
endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer driving a shared Montgomery multiplier.
// Define MOD_EXP_CTRL_LZ_SKIP_EN to start at the exponent's MSB and short-cut exp=0.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] one_m,
  input  logic [WIDTH-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_z
);
  localparam int IW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d, a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d, idx_init;
  logic             skip;
`ifdef MOD_EXP_CTRL_LZ_SKIP_EN
  lz_msb_find #(.WIDTH(WIDTH)) u_msb (.vec_i(exp), .msb_o(idx_init));
  assign skip = (exp == '0);
`else
  assign idx_init = IW'(WIDTH - 1);
  assign skip     = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        base_d  = base;
        exp_d   = exp;
        acc_d   = one_m;
        idx_d   = idx_init;
        state_d = skip ? DONE : SQR_ISSUE;
      end
      SQR_ISSUE: state_d = SQR_WAIT;
      SQR_WAIT: if (mm_done) begin
        acc_d   = mm_z;
        state_d = exp_q[idx_q] ? MUL_ISSUE : NEXT;
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT: if (mm_done) begin
        acc_d   = mm_z;
        state_d = NEXT;
      end
      NEXT: begin
        state_d = (idx_q == '0) ? DONE : SQR_ISSUE;
        idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Operand registers load on entry to an issue state so they hold through the wait.
    a_d   = (state_d == SQR_ISSUE || state_d == MUL_ISSUE) ? acc_d : a_q;
    b_d   = (state_d == MUL_ISSUE) ? base_d : (state_d == SQR_ISSUE) ? acc_d : b_q;
    res_d = (state_d == DONE) ? acc_d : res_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      exp_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign mm_start = (state_q == SQR_ISSUE) || (state_q == MUL_ISSUE);
  assign mm_a     = a_q;
  assign mm_b     = b_q;
  assign result   = res_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: randomized and directed checks of mod_exp_ctrl against a square-and-multiply model.
module tb_mod_exp_ctrl;
  localparam int W = 8;
  localparam int P = 251;
`ifdef MOD_EXP_CTRL_LZ_SKIP_EN
  localparam int P35 = 5;
  localparam int P0  = 0;
`else
  localparam int P35 = 10;
  localparam int P0  = 8;
`endif
  logic clk = 0, reset_n = 0, start = 0;
  logic [W-1:0] base_i = 0, one_m_i = 1, exp_i = 0;
  logic busy, done, mm_start, mm_done, mm_done_m = 0, stray = 0;
  logic [W-1:0] result, mm_a, mm_b, mm_z, mm_z_m = 0, pa = 0, pb = 0, ha = 0, hb = 0;
  int cnt = 0, n_chk = 0, n_err = 0, n_start = 0, n_done = 0;
  int exp_res = 0, exp_pulses = 0, res_model = 0;
  logic [15:0] opq[$];
  logic [15:0] ev;
  logic waiting = 0;

  mod_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset_n), .start(start), .base(base_i), .one_m(one_m_i), .exp(exp_i),
    .busy(busy), .done(done), .result(result), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_done(mm_done), .mm_z(mm_z)
  );

  always #5 clk = ~clk;
  assign mm_done = mm_done_m | stray;
  assign mm_z    = stray ? 8'd123 : mm_z_m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 0;
      mm_done_m <= 0;
    end else begin
      mm_done_m <= 0;
      if (mm_start) begin
        cnt <= 4;
        pa  <= mm_a;
        pb  <= mm_b;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          mm_done_m <= 1;
          mm_z_m    <= W'((int'(pa) * int'(pb)) % P);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) waiting = 0;
    else begin
      if (waiting) begin
        chk("mm_a_stable", mm_a, ha);
        chk("mm_b_stable", mm_b, hb);
        if (mm_done) waiting = 0;
      end
      if (mm_start) begin
        if (opq.size() == 0) chk("mm_unexpected_start", 1, 0);
        else begin
          ev = opq.pop_front();
          chk("mm_a", mm_a, ev[15:8]);
          chk("mm_b", mm_b, ev[7:0]);
        end
        ha = mm_a;
        hb = mm_b;
        waiting = 1;
        n_start++;
      end
      if (done) begin
        chk("result_at_done", result, exp_res);
        res_model = exp_res;
        n_done++;
      end else chk("result_hold", result, res_model);
    end
  end

  task automatic model_push(input logic [W-1:0] b, input logic [W-1:0] e);
    int acc = 1;
    int top = W - 1;
`ifdef MOD_EXP_CTRL_LZ_SKIP_EN
    top = -1;
    for (int i = 0; i < W; i++) if (e[i]) top = i;
`endif
    exp_pulses = 0;
    for (int i = top; i >= 0; i--) begin
      opq.push_back({acc[7:0], acc[7:0]});
      acc = (acc * acc) % P;
      exp_pulses++;
      if (e[i]) begin
        opq.push_back({acc[7:0], b});
        acc = (acc * int'(b)) % P;
        exp_pulses++;
      end
    end
    exp_res = acc;
  endtask

  task automatic op_start(input logic [W-1:0] b, input logic [W-1:0] e);
    int g = 0;
    @(posedge clk); #1;
    while ((busy || done) && g < 600) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 600) chk("idle_timeout", g, 0);
    base_i = b;
    exp_i  = e;
    start  = 1;
    @(posedge clk); #1;
    start = 0;
    model_push(b, e);
  endtask

  task automatic wait_done(input string nm, input int n0, input int d0);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 600);
    if (g >= 600) chk({nm, "_done_timeout"}, g, 0);
    chk({nm, "_pulses"}, n_start - n0, exp_pulses);
    chk({nm, "_result"}, result, exp_res);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_done_count"}, n_done - d0, 1);
  endtask

  task automatic run(input string nm, input logic [W-1:0] b, input logic [W-1:0] e);
    int n0 = n_start, d0 = n_done;
    op_start(b, e);
    wait_done(nm, n0, d0);
  endtask

  initial begin
    int n0, d0, r1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_result", result, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    n0 = n_start;
    run("b3_e05", 8'd3, 8'h05);
    chk("pin_b3_e05", result, 243);
    chk("pin_b3_e05_pulses", n_start - n0, P35);

    n0 = n_start;
    run("b7_e00", 8'd7, 8'h00);
    chk("pin_b7_e00", result, 1);
    chk("pin_b7_e00_pulses", n_start - n0, P0);

    run("b2_eff", 8'd2, 8'hFF);
    chk("pin_b2_eff", result, 32);

    // second start during SQR_WAIT must be ignored
    n0 = n_start; d0 = n_done;
    op_start(8'd5, 8'h93);
    @(posedge clk); #1;
    base_i = 8'd9; exp_i = 8'h44; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done("ignore_start", n0, d0);

    // reset during MUL_WAIT, then a stray multiplier response
    op_start(8'd3, 8'h80);
    repeat (7) @(posedge clk);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mm_start", mm_start, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    opq.delete();
    res_model = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1 stray = 1;
    @(posedge clk); #1 stray = 0;
    chk("stray_busy", busy, 0);
    chk("stray_result", result, 0);
    repeat (2) @(posedge clk);
    #1 chk("stray_idle", busy, 0);
    run("b2_e08", 8'd2, 8'h08);
    chk("pin_b2_e08", result, 5);

    // back-to-back with start held high
    @(posedge clk); #1;
    n0 = n_start; d0 = n_done;
    base_i = 8'd4; exp_i = 8'h2A; start = 1;
    @(posedge clk); #1;
    model_push(8'd4, 8'h2A);
    r1 = exp_res;
    base_i = 8'd6; exp_i = 8'h11;
    begin
      int g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!done && g < 600);
      if (g >= 600) chk("b2b_done_timeout", g, 0);
    end
    chk("b2b_first_result", result, r1);
    chk("b2b_first_pulses", n_start - n0, exp_pulses);
    @(posedge clk); #1;
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_result", result, r1);
    n0 = n_start; d0 = n_done;
    @(posedge clk); #1;
    start = 0;
    model_push(8'd6, 8'h11);
    chk("b2b_second_accepted", busy | done, 1);
    wait_done("b2b_second", n0, d0);

    for (int k = 0; k < 16; k++)
      run("rand", W'($urandom_range(0, P - 1)), W'($urandom_range(0, 255)));

    chk("queue_drained", opq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
